// File: rtl/dht11_pkg.sv
// dht11_pkg: shared definitions for the DHT11 single-wire protocol.
// Holds the state encoding, default timing constants (us) and frame size,
// used by both the sensor-side responder and the host-side reader.
package dht11_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HOST_LOW  = 3'd1,
    ST_RESP_WAIT = 3'd2,
    ST_ACK_LOW   = 3'd3,
    ST_ACK_HIGH  = 3'd4,
    ST_BIT_LOW   = 3'd5,
    ST_BIT_HIGH  = 3'd6,
    ST_END_LOW   = 3'd7
  } dht11_state_t;

  localparam int DHT11_CLK_DIV       = 50;
  localparam int DHT11_START_MIN_US  = 18000;
  localparam int DHT11_RESP_DELAY_US = 30;
  localparam int DHT11_ACK_LOW_US    = 80;
  localparam int DHT11_ACK_HIGH_US   = 80;
  localparam int DHT11_BIT_LOW_US    = 50;
  localparam int DHT11_BIT0_HIGH_US  = 26;
  localparam int DHT11_BIT1_HIGH_US  = 70;
  localparam int FRAME_BITS          = 40;

  // Sum of the four payload bytes, wrapped to 8 bits.
  function automatic logic [7:0] dht11_checksum(input logic [31:0] d);
    return d[31:24] + d[23:16] + d[15:8] + d[7:0];
  endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// dht11_us_tick: free-running prescaler producing a one-clk tick every
// CLK_DIV clocks (1 us at the nominal clock).
// Ports: clk, rst_n (async, active-low), tick (registered 1-clk pulse).
module dht11_us_tick
  import dht11_pkg::*;
#(
  parameter int CLK_DIV = DHT11_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (div_cnt == LAST);
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dht11_responder.sv
// dht11_responder: sensor side of the DHT11 single-wire protocol.
// Waits for a host start pulse, then sends ack and a 40-bit frame
// {data_in, checksum} MSB first.
// Ports: clk, rst_n (async, active-low), dht_in (raw bus level),
//   dht_oe (1 = pull bus low, registered), en (accept start requests),
//   data_in {hum_int, hum_dec, temp_int, temp_dec}, busy (ack..end low),
//   frame_done (1-clk pulse on return to idle after a frame).
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int CLK_DIV       = DHT11_CLK_DIV,
  parameter int START_MIN_US  = DHT11_START_MIN_US,
  parameter int RESP_DELAY_US = DHT11_RESP_DELAY_US,
  parameter int ACK_LOW_US    = DHT11_ACK_LOW_US,
  parameter int ACK_HIGH_US   = DHT11_ACK_HIGH_US,
  parameter int BIT_LOW_US    = DHT11_BIT_LOW_US,
  parameter int BIT0_HIGH_US  = DHT11_BIT0_HIGH_US,
  parameter int BIT1_HIGH_US  = DHT11_BIT1_HIGH_US
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dht_in,
  output logic        dht_oe,
  input  logic        en,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [15:0] T_START = 16'(START_MIN_US);
  localparam logic [15:0] T_RESP  = 16'(RESP_DELAY_US);
  localparam logic [15:0] T_ACKL  = 16'(ACK_LOW_US);
  localparam logic [15:0] T_ACKH  = 16'(ACK_HIGH_US);
  localparam logic [15:0] T_BITL  = 16'(BIT_LOW_US);
  localparam logic [15:0] T_BIT0  = 16'(BIT0_HIGH_US);
  localparam logic [15:0] T_BIT1  = 16'(BIT1_HIGH_US);
  localparam logic [5:0]  N_BITS  = 6'(FRAME_BITS);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic drives_low(input dht11_state_t s);
    return (s == ST_ACK_LOW) || (s == ST_BIT_LOW) || (s == ST_END_LOW);
  endfunction

  function automatic logic is_busy(input dht11_state_t s);
    return (s == ST_ACK_LOW) || (s == ST_ACK_HIGH) || (s == ST_BIT_LOW) ||
           (s == ST_BIT_HIGH) || (s == ST_END_LOW);
  endfunction

  logic                  tick;
  logic                  dht_p0, dht_p1, dht_p2;
  logic                  bus_rise;
  dht11_state_t          state, state_nxt;
  logic [15:0]           us_cnt;
  logic [5:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [15:0]           bit_dur;
  logic                  load, shift_en, done_nxt;

  dht11_us_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // p0/p1: two-FF synchronizer; p2: previous synced level for edge detect.
  // Reset to the idle (pulled-up) level so reset release is not a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dht_p0 <= 1'b1;
      dht_p1 <= 1'b1;
      dht_p2 <= 1'b1;
    end else begin
      dht_p0 <= dht_in;
      dht_p1 <= dht_p0;
      dht_p2 <= dht_p1;
    end
  end

  assign bus_rise = dht_p1 & ~dht_p2;
  assign bit_dur  = shift_reg[FRAME_BITS-1] ? T_BIT1 : T_BIT0;

  // Next-state decision. The bus is only looked at in IDLE, HOST_LOW and
  // RESP_WAIT; while we drive or release the line it is ignored.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE:      if (en && !dht_p1) state_nxt = ST_HOST_LOW;
      ST_HOST_LOW:  if (bus_rise) state_nxt = (us_cnt >= T_START) ? ST_RESP_WAIT : ST_IDLE;
      ST_RESP_WAIT: begin
        if (!dht_p1) begin
          state_nxt = ST_HOST_LOW;
        end else if (us_cnt >= T_RESP) begin
          state_nxt = ST_ACK_LOW;
          load      = 1'b1;
        end
      end
      ST_ACK_LOW:   if (us_cnt >= T_ACKL) state_nxt = ST_ACK_HIGH;
      ST_ACK_HIGH:  if (us_cnt >= T_ACKH) state_nxt = ST_BIT_LOW;
      ST_BIT_LOW:   if (us_cnt >= T_BITL) state_nxt = ST_BIT_HIGH;
      ST_BIT_HIGH: begin
        if (us_cnt >= bit_dur) begin
          shift_en  = 1'b1;
          state_nxt = ((bit_cnt + 6'd1) < N_BITS) ? ST_BIT_LOW : ST_END_LOW;
        end
      end
      ST_END_LOW: begin
        if (us_cnt >= T_BITL) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same
  // edge as the state register and never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      dht_oe     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      us_cnt     <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
    end else begin
      state      <= state_nxt;
      dht_oe     <= drives_low(state_nxt);
      busy       <= is_busy(state_nxt);
      frame_done <= done_nxt;
      if (state_nxt != state) us_cnt <= '0;
      else if (tick)          us_cnt <= sat_inc(us_cnt);
      if (load) begin
        shift_reg <= {data_in, dht11_checksum(data_in)};
        bit_cnt   <= '0;
      end else if (shift_en) begin
        shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
        bit_cnt   <= bit_cnt + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: drives host start pulses through an open-drain bus
// model (pull-up, host and responder both pull low) and decodes the
// responder's pulses as a DHT11 reader would.
module tb_dht11_responder;

  localparam int CD   = 2;
  localparam int SMIN = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        host_low;
  logic [31:0] data_in;
  logic        dht_in;
  logic        dht_oe;
  logic        busy;
  logic        frame_done;

  // Open-drain bus with pull-up.
  assign dht_in = ~(dht_oe | host_low);

  always #5 clk = ~clk;

  dht11_responder #(
    .CLK_DIV      (CD),
    .START_MIN_US (SMIN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dht_in     (dht_in),
    .dht_oe     (dht_oe),
    .en         (en),
    .data_in    (data_in),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Activity monitors (counts only ever increase).
  int   oe_rises    = 0;
  int   busy_cycles = 0;
  logic oe_q        = 1'b0;
  always @(posedge clk) begin
    oe_q <= dht_oe;
    if (dht_oe && !oe_q) oe_rises <= oe_rises + 1;
    if (busy) busy_cycles <= busy_cycles + 1;
  end

  // Expected frame: payload followed by the byte sum modulo 256.
  function automatic logic [39:0] ref_frame(input logic [31:0] d);
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'((d >> (8 * i)) & 32'hFF);
    return {d, 8'(s % 256)};
  endfunction

  function automatic bit in_win(input int w, input int d);
    return (w >= (d - 1) * CD) && (w <= d * CD + 2);
  endfunction

  task automatic wait_oe(input logic val, input int max_clk, output int clks, output bit to);
    clks = 0;
    do begin
      @(negedge clk);
      clks++;
    end while (dht_oe !== val && clks < max_clk);
    to = (dht_oe !== val);
  endtask

  task automatic host_start(input int us);
    host_low = 1'b1;
    repeat (us * CD) @(negedge clk);
    host_low = 1'b0;
  endtask

  // Decodes one response; pulse widths are oe-high (bus low) / oe-low times.
  task automatic receive(input string tag, input bit zap_data, input bit drop_en,
                         output logic [39:0] frame);
    int w;
    bit to;
    bit b;
    int nbad = 0;
    frame = '0;
    wait_oe(1'b1, 40 * CD + 20, w, to);
    if (to) begin check({tag, " ack timeout"}, 0, 1); return; end
    if (w < 29 * CD || w > 30 * CD + 8) nbad++;
    check({tag, " busy"}, busy, 1);
    wait_oe(1'b0, 100 * CD, w, to);
    if (to) begin check({tag, " acklow timeout"}, 0, 1); return; end
    if (!in_win(w, 80)) nbad++;
    if (zap_data) data_in = 32'h0;
    if (drop_en) en = 1'b0;
    wait_oe(1'b1, 100 * CD, w, to);
    if (to) begin check({tag, " ackhigh timeout"}, 0, 1); return; end
    if (!in_win(w, 80)) nbad++;
    for (int i = 0; i < 40; i++) begin
      wait_oe(1'b0, 100 * CD, w, to);
      if (to) begin check({tag, " bitlow timeout"}, 0, 1); return; end
      if (!in_win(w, 50)) nbad++;
      wait_oe(1'b1, 100 * CD, w, to);
      if (to) begin check({tag, " bithigh timeout"}, 0, 1); return; end
      b = (w > 48 * CD);
      frame[39 - i] = b;
      if (!in_win(w, b ? 70 : 26)) nbad++;
    end
    wait_oe(1'b0, 100 * CD, w, to);
    if (to) begin check({tag, " endlow timeout"}, 0, 1); return; end
    if (!in_win(w, 50)) nbad++;
    check({tag, " frame_done"}, frame_done, 1);
    check({tag, " busy_end"}, busy, 0);
    @(negedge clk);
    check({tag, " done_pulse"}, frame_done, 0);
    check({tag, " timing"}, nbad, 0);
    en = 1'b1;
  endtask

  initial begin
    logic [39:0] f;
    logic [39:0] exp_f;
    int r0, b0;

    rst_n = 1'b0; en = 1'b1; host_low = 1'b0; data_in = 32'h0;
    repeat (3) @(negedge clk);
    check("rst oe", dht_oe, 0);
    check("rst busy", busy, 0);
    check("rst done", frame_done, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Nominal frame.
    data_in = 32'h37001A05;
    host_start(SMIN + 50);
    receive("t026", 1'b0, 1'b0, f);
    check("t026 frame", f, ref_frame(32'h37001A05));
    repeat (20) @(negedge clk);

    // Short host pulse is not a start.
    r0 = oe_rises; b0 = busy_cycles;
    host_start(SMIN / 2);
    repeat (200 * CD) @(negedge clk);
    check("t027 oe", oe_rises - r0, 0);
    check("t027 busy", busy_cycles - b0, 0);

    // Disabled, then enabled.
    en = 1'b0;
    r0 = oe_rises; b0 = busy_cycles;
    host_start(SMIN + 50);
    repeat (200 * CD) @(negedge clk);
    check("t028 oe", oe_rises - r0, 0);
    check("t028 busy", busy_cycles - b0, 0);
    en = 1'b1;
    repeat (10) @(negedge clk);
    data_in = $urandom;
    exp_f = ref_frame(data_in);
    host_start(SMIN + 50);
    receive("t028", 1'b0, 1'b0, f);
    check("t028 frame", f, exp_f);
    repeat (20) @(negedge clk);

    // Checksum wrap; payload changes after load must not matter.
    data_in = 32'hFFFF0102;
    exp_f = ref_frame(data_in);
    host_start(SMIN + 50);
    receive("t029", 1'b1, 1'b0, f);
    check("t029 frame", f, exp_f);
    repeat (20) @(negedge clk);

    // Reset during bit 20.
    data_in = $urandom;
    r0 = oe_rises;
    host_start(SMIN + 50);
    for (int k = 0; k < 8000 && (oe_rises - r0) < 22; k++) @(negedge clk);
    check("t030 reach", (oe_rises - r0) >= 22, 1);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t030 oe", dht_oe, 0);
    check("t030 busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    data_in = $urandom;
    exp_f = ref_frame(data_in);
    host_start(SMIN + 50);
    receive("t030", 1'b0, 1'b0, f);
    check("t030 frame", f, exp_f);
    repeat (20) @(negedge clk);

    // Random payloads, en possibly dropped mid-frame.
    for (int n = 0; n < 2; n++) begin
      data_in = $urandom;
      exp_f = ref_frame(data_in);
      host_start(SMIN + int'($urandom_range(10, 60)));
      receive("rnd", 1'b0, 1'($urandom_range(0, 1)), f);
      check("rnd frame", f, exp_f);
      repeat (20) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
